// File: rtl/tl_a_pkg.sv
// TileLink A-channel types, widths and opcode helpers shared by the repeater slice.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tl_a_pkg;

    localparam int ADDR_W   = 30;
    localparam int SRC_W    = 5;
    localparam int SIZE_W   = 4;
    localparam int MASK_W   = 4;
    localparam int LOG_MASK = $clog2(MASK_W);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;
    localparam logic [2:0] OP_ACQUIRE     = 3'd6;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] address;
        logic [MASK_W-1:0] mask;
        logic              corrupt;
    } a_beat_t;

    // Puts and atomics carry a data payload; Get/Hint/Acquire are single-beat.
    function automatic logic has_data(input logic [2:0] opcode);
        return (opcode <= OP_LOGIC);
    endfunction

endpackage

// File: rtl/tl_a_repeater_if.sv
// A-channel valid/ready link carrying one a_beat_t per transfer.
// Latency: n/a (wires only).
// Backpressure: ready driven by the sink, valid/beat by the source.
interface tl_a_if;
    import tl_a_pkg::*;

    logic    valid;
    logic    ready;
    a_beat_t beat;

    modport master (output valid, output beat, input  ready);
    modport slave  (input  valid, input  beat, output ready);

endinterface

// File: rtl/tl_beat_tracker.sv
// Tracks beat position inside multi-beat A messages on the deq side.
// Latency: deq_first/beat_left update one cycle after each advancing deq fire.
// Backpressure: none; only observes deq_fire, repeated beats do not advance.
// Ports: clock/reset, deq_fire + repeat_en strobes, opcode/size of the current
// deq beat, deq_first (registered position), multi_beat (current message > 1 beat).
module tl_beat_tracker
    import tl_a_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              deq_fire,
    input  logic              repeat_en,
    input  logic [2:0]        opcode,
    input  logic [SIZE_W-1:0] size,
    output logic              deq_first,
    output logic              multi_beat
);

    // Largest message is 2^(2^SIZE_W-1) bytes, so beats-1 needs this many bits.
    localparam int BEAT_W = (1 << SIZE_W) - 1 - LOG_MASK;
    localparam logic [BEAT_W:0] ONE = 1;

    logic [BEAT_W-1:0] beat_left;
    logic [BEAT_W-1:0] beats_m1;
    logic [BEAT_W:0]   span;
    logic [BEAT_W:0]   span_m1;

    always_comb begin
        span     = ONE;
        span_m1  = '0;
        beats_m1 = '0;
        if (has_data(opcode) && (size > SIZE_W'(LOG_MASK))) begin
            span     = ONE << (size - SIZE_W'(LOG_MASK));
            span_m1  = span - ONE;
            beats_m1 = span_m1[BEAT_W-1:0];
        end
    end

    assign multi_beat = (beats_m1 != '0);
    assign deq_first  = (beat_left == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_left <= '0;
        end else if (deq_fire && !repeat_en) begin
            if (beat_left == '0) begin
                beat_left <= beats_m1;
            end else begin
                beat_left <= beat_left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_a_repeater.sv
// Single-entry A-channel repeater: bypasses beats, captures one on repeat and re-issues it.
// Latency: zero when empty (combinational bypass); captured beat re-presented from the next cycle.
// Backpressure: enq_ready = deq.ready & ~full, so upstream stalls for the whole repeat window.
// Ports: clock/reset; enq (slave) and deq (master) A links; repeat_en (hold current deq
// beat for re-issue); status full, deq_first, repeat_cnt (saturating captures), err (sticky).
module tl_a_repeater
    import tl_a_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    tl_a_if.slave            enq,
    tl_a_if.master           deq,
    input  logic             repeat_en,
    output logic             full,
    output logic             deq_first,
    output logic [CNT_W-1:0] repeat_cnt,
    output logic             err
);

    a_beat_t saved;
    logic    enq_fire;
    logic    deq_fire;
    logic    capture;
    logic    multi_beat;

    assign enq.ready = deq.ready & ~full;
    assign deq.valid = enq.valid | full;
    assign deq.beat  = full ? saved : enq.beat;

    assign enq_fire = enq.valid & enq.ready;
    assign deq_fire = deq.valid & deq.ready;
    // enq_fire implies ~full, so capture never overlaps a release.
    assign capture  = enq_fire & repeat_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            full       <= 1'b0;
            saved      <= '0;
            repeat_cnt <= '0;
            err        <= 1'b0;
        end else begin
            if (capture) begin
                full  <= 1'b1;
                saved <= enq.beat;
            end else if (deq_fire && !repeat_en) begin
                full  <= 1'b0;
            end

            if (capture && (repeat_cnt != '1)) begin
                repeat_cnt <= repeat_cnt + CNT_W'(1);
            end

            // Only a lone single-beat message may be repeated.
            if (deq_fire && repeat_en && (multi_beat || !deq_first)) begin
                err <= 1'b1;
            end
        end
    end

    tl_beat_tracker u_beat_tracker (
        .clock      (clock),
        .reset      (reset),
        .deq_fire   (deq_fire),
        .repeat_en  (repeat_en),
        .opcode     (deq.beat.opcode),
        .size       (deq.beat.size),
        .deq_first  (deq_first),
        .multi_beat (multi_beat)
    );

endmodule
